mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single Avalon-style memory master port between the instruction-fetch requester and the load/store data requester of the multi-cycle MIPS core. It grants one requester at a time and holds address and controls stable while `waitrequest` is high. It captures returned read data and acknowledges the requester with a one-cycle pulse. It sits between the core's state machine (fetch/exec1/exec2) and the external memory bus, and stops issuing new transactions while `halt` is asserted.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byteenable width is DATA_W/8.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `halt`  in  1  high = no new grants; an in-flight transaction completes.
- `i_read`  in  1  instruction fetch request; held until `i_ack`.
- `i_address`  in  ADDR_W  fetch address; stable while `i_read` is high.
- `i_readdata`  out  DATA_W  registered fetch data; valid in the `i_ack` cycle and held until the next `i_ack`.
- `i_ack`  out  1  one-cycle completion pulse.
- `d_read`, `d_write`  in  1 each  data request; held until `d_ack`.
- `d_address`  in  ADDR_W  data address.
- `d_writedata`  in  DATA_W  store data.
- `d_byteenable`  in  DATA_W/8  store/load byte lanes.
- `d_readdata`  out  DATA_W  registered load data; same validity rule as `i_readdata`.
- `d_ack`  out  1  one-cycle completion pulse.
- `address`  out  ADDR_W  master address.
- `read`, `write`  out  1 each  master strobes.
- `writedata`  out  DATA_W  master write data.
- `byteenable`  out  DATA_W/8  master byte lanes.
- `readdata`  in  DATA_W  master read data; valid in the cycle where `read`=1 and `waitrequest`=0.
- `waitrequest`  in  1  bus stall.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUS_I, BUS_D, RESP. Register `last` (I/D) records the last granted requester.
- IDLE, `halt`=1: stay in IDLE and issue no grant.
- IDLE, `halt`=0, only one requester pending: grant it.
- IDLE, `halt`=0, both pending: grant the requester not equal to `last` (round-robin).
- On a grant:
  - Register address, writedata, byteenable and op into master-side registers.
  - Set `last` to the granted requester.
  - Go to BUS_I or BUS_D.
- BUS_x:
  - Drive `read` or `write` from the registered op; all master outputs come from registers.
  - `waitrequest`=1: stay in BUS_x with every master output unchanged.
  - `waitrequest`=0: the transfer completes. For a read, capture `readdata` into the `i_readdata` or `d_readdata` register. Go to RESP.
- RESP: pulse the matching ack for one cycle, then return to IDLE. No grant is issued in RESP.
- Requesters drop their request in the cycle after ack. A request still high in IDLE is treated as a new transaction.
- `d_read` and `d_write` both high: treated as a write, and `read` stays 0.
- `halt` changing mid-transaction has no effect on that transaction.
- Master `read`, `write`, `address`, `writedata` and `byteenable` are 0 in IDLE and RESP.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, `last` = D (so the first tie goes to I);
  - all outputs, including `busy`, `i_readdata` and `d_readdata`, to 0.
- Reset mid-transaction drops `read`/`write` immediately and discards the transaction; no ack is issued.
- Minimum latency with no wait states:
  - request seen high at edge 0;
  - master strobe high during cycle 1;
  - ack high during cycle 2;
  - IDLE in cycle 3.
- Each `waitrequest`=1 cycle in BUS_x adds exactly one cycle.
- Back-to-back transactions to alternating requesters take 3 cycles each.
- `busy` is registered: it is high from the cycle after the grant through the RESP cycle.

## Test plan
- Reset then `i_read`=1, `i_address`=0xBFC00000, `waitrequest`=0, `readdata`=0x24020005 → `read`=1 with address 0xBFC00000 in cycle 1; `i_ack`=1 and `i_readdata`=0x24020005 in cycle 2; `busy` low in cycle 3.
- `d_write`=1, `d_address`=0x1000, `d_writedata`=0xDEADBEEF, `d_byteenable`=0xF, with `waitrequest` high for 3 cycles → `write`, address and data held constant for 4 cycles; `d_ack` in the 5th cycle after the request edge.
- After reset, `i_read` and `d_read` both asserted continuously, each requester dropping its request for one cycle after each ack → grants are I, D, I, D; acks alternate, 3 cycles apart.
- `halt`=1 with `i_read`=1 held for 10 cycles → `read` stays 0 and `busy` stays 0. After `halt` is released, the normal 3-cycle fetch completes.
- `halt` raised in the cycle after a grant while `waitrequest`=1 → the transaction completes and acks; no further grant while `halt`=1.
- `reset` pulsed while in BUS_D with `waitrequest`=1 → `write`=0 and `busy`=0 immediately, with no `d_ack`. A subsequent `d_read` completes normally with `readdata`=0x12345678 → `d_readdata`=0x12345678.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-style master port between the
// instruction-fetch and load/store requesters of a multi-cycle core.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_ack,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_ack,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                waitrequest,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;

  state_t state;
  logic   last_d;
  logic   i_pend, d_pend;
  logic   grant_i, grant_d;

  // On a tie the requester that was not served last wins.
  assign i_pend  = i_read;
  assign d_pend  = d_read | d_write;
  assign grant_i = !halt && i_pend && (!d_pend || last_d);
  assign grant_d = !halt && d_pend && (!i_pend || !last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_d     <= 1'b1;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_readdata <= '0;
      d_readdata <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state      <= BUS_I;
            last_d     <= 1'b0;
            address    <= i_address;
            read       <= 1'b1;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '1;
            busy       <= 1'b1;
          end else if (grant_d) begin
            // A simultaneous read and write request is issued as a write.
            state      <= BUS_D;
            last_d     <= 1'b1;
            address    <= d_address;
            read       <= !d_write;
            write      <= d_write;
            writedata  <= d_writedata;
            byteenable <= d_byteenable;
            busy       <= 1'b1;
          end
        end
        BUS_I, BUS_D: begin
          if (!waitrequest) begin
            if (read) begin
              if (state == BUS_I) i_readdata <= readdata;
              else                d_readdata <= readdata;
            end
            i_ack      <= (state == BUS_I);
            d_ack      <= (state == BUS_D);
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand-written corner sequences,
// with a queue-based scoreboard acting as bus slave and ack checker.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, halt;
  logic        i_read, d_read, d_write;
  logic [31:0] i_address, d_address, d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] i_readdata, d_readdata;
  logic        i_ack, d_ack;
  logic [31:0] address, writedata;
  logic        read, write, busy;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;
  logic        waitrequest = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_ack(i_ack),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(d_readdata), .d_ack(d_ack),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
    .busy(busy)
  );

  typedef struct {
    logic        is_d;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic        exp_read;
    logic        exp_write;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        exp_read;
    logic        exp_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_bus = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // e0 is the clock edge at which the request is first seen.
  task automatic push(input vec_t v, input int e0);
    exp_t e;
    e.is_d = v.is_d; e.exp_read = v.exp_read; e.exp_write = v.exp_write;
    e.addr = v.addr; e.wdata = v.wdata; e.be = v.be; e.waits = v.waits;
    e.rdata = v.rdata; e.ack_cyc = e0 + 1 + v.waits;
    exp_q.push_back(e);
  endtask

  // Scoreboard and bus slave: checks master outputs and acks, drives waitrequest/readdata.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      n_bus = 0;
      waitrequest <= 1'b0;
      readdata    <= '0;
    end else begin
      if (read || write) begin
        if (exp_q.size() == 0) check("unexpected_bus", 1, 0);
        else begin
          n_bus++;
          check("bus_read", read, exp_q[0].exp_read);
          check("bus_write", write, exp_q[0].exp_write);
          check("bus_addr", address, exp_q[0].addr);
          if (exp_q[0].exp_write) check("bus_wdata", writedata, exp_q[0].wdata);
          if (exp_q[0].is_d) check("bus_be", byteenable, exp_q[0].be);
        end
      end
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("ack_i", i_ack, !e.is_d);
          check("ack_d", d_ack, e.is_d);
          check("ack_cycle", cyc, e.ack_cyc);
          check("bus_cycles", n_bus, e.waits + 1);
          if (e.exp_read) begin
            if (e.is_d) check("d_readdata", d_readdata, e.rdata);
            else        check("i_readdata", i_readdata, e.rdata);
          end
          n_bus = 0;
        end
      end
      waitrequest <= (read || write) && (exp_q.size() != 0) && (n_bus <= exp_q[0].waits);
      readdata    <= (exp_q.size() != 0) ? exp_q[0].rdata : 32'h0;
    end
  end

  task automatic drive(input vec_t v);
    if (v.is_d) begin
      d_read = v.rd; d_write = v.wr; d_address = v.addr;
      d_writedata = v.wdata; d_byteenable = v.be;
    end else begin
      i_read = 1'b1; i_address = v.addr;
    end
  endtask

  task automatic finish_req(input logic is_d);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #1;
      if (is_d ? d_ack : i_ack) ok = 1'b1;
    end
    if (!ok) check("ack_timeout", 1, 0);
    else begin
      check("resp_busy", busy, 1);
      check("resp_bus_idle", {read, write, address}, 0);
    end
    @(posedge clk); #1;
    if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
    else i_read = 1'b0;
    check("post_busy", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    push(v, cyc + 1);
    drive(v);
    finish_req(v.is_d);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    vec_t v;
    int   acks;
    logic pi, pd;

    vt[0] = '{1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'h0, 0, 32'h24020005, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'hF, 3, 32'h0,        1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h00002004, 32'h0,        4'h3, 1, 32'hCAFEF00D, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'h00003000, 32'h55AA55AA, 4'hC, 0, 32'h13579BDF, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h00400010, 32'h0,        4'h0, 2, 32'h8C880004, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 0, 32'hFFFFFFFF, 1'b1, 1'b0};

    reset = 1'b1; halt = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobes_acks", {read, write, i_ack, d_ack}, 0);
    check("rst_addr", address, 0);
    check("rst_wdata_be", {writedata, byteenable}, 0);
    check("rst_readdata", {i_readdata, d_readdata}, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Both requesters pending after reset: expect I, D, I, D three cycles apart.
    pulse_reset();
    @(posedge clk); #1;
    v = '{1'b0, 1'b1, 1'b0, 32'h00000100, 32'h0, 4'hF, 0, 32'h11111111, 1'b1, 1'b0};
    push(v, cyc + 1);
    v = '{1'b1, 1'b1, 1'b0, 32'h00000200, 32'h0, 4'hF, 0, 32'h22222222, 1'b1, 1'b0};
    push(v, cyc + 4);
    v = '{1'b0, 1'b1, 1'b0, 32'h00000100, 32'h0, 4'hF, 0, 32'h33333333, 1'b1, 1'b0};
    push(v, cyc + 7);
    v = '{1'b1, 1'b1, 1'b0, 32'h00000200, 32'h0, 4'hF, 0, 32'h44444444, 1'b1, 1'b0};
    push(v, cyc + 10);
    i_address = 32'h100; d_address = 32'h200; d_byteenable = 4'hF;
    i_read = 1'b1; d_read = 1'b1;
    acks = 0; pi = 1'b0; pd = 1'b0;
    for (int k = 0; k < 60 && acks < 4; k++) begin
      @(posedge clk); #1;
      if (i_ack) acks++;
      if (d_ack) acks++;
      if (acks >= 4) begin i_read = 1'b0; d_read = 1'b0; end
      else begin i_read = !pi; d_read = !pd; end
      pi = i_ack; pd = d_ack;
    end
    check("rr_ack_count", acks, 4);
    repeat (2) @(posedge clk);
    #1;
    check("rr_queue_empty", exp_q.size(), 0);

    // Halt blocks a pending fetch; release lets it complete normally.
    @(posedge clk); #1;
    halt = 1'b1; i_read = 1'b1; i_address = 32'hBFC00000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("halt_idle", {read, busy}, 0);
    end
    v = '{1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'h0, 0, 32'h24020005, 1'b1, 1'b0};
    push(v, cyc + 1);
    halt = 1'b0;
    finish_req(1'b0);

    // Halt raised after a grant: the transfer finishes, then no new grant.
    @(posedge clk); #1;
    v = '{1'b1, 1'b1, 1'b0, 32'h00002000, 32'h0, 4'hF, 3, 32'h0BADF00D, 1'b1, 1'b0};
    push(v, cyc + 1);
    drive(v);
    @(posedge clk); #1;
    halt = 1'b1; i_read = 1'b1; i_address = 32'h00000500;
    finish_req(1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("halt_no_grant", {read, write, busy}, 0);
    end
    v = '{1'b0, 1'b1, 1'b0, 32'h00000500, 32'h0, 4'h0, 0, 32'h600DC0DE, 1'b1, 1'b0};
    push(v, cyc + 1);
    halt = 1'b0;
    finish_req(1'b0);

    // Reset in the middle of a stalled write discards it without an ack.
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'hF, 100, 32'h0, 1'b0, 1'b1};
    push(v, cyc + 1);
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_write", {write, busy}, 2'b11);
    reset = 1'b1;
    #1;
    check("reset_drops_write", write, 0);
    check("reset_drops_busy", busy, 0);
    check("reset_no_ack", d_ack, 0);
    exp_q.delete();
    d_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("post_reset_quiet", {d_ack, busy, write}, 0);
    end
    v = '{1'b1, 1'b1, 1'b0, 32'h00000040, 32'h0, 4'hF, 0, 32'h12345678, 1'b1, 1'b0};
    run_vec(v);
    check("d_readdata_held", d_readdata, 32'h12345678);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
